// File: rtl/fir_mc_pkg.sv
// ============================================================================
// fir_mc_pkg : shared FSM encoding and width helpers for fir_filter_mc
// Rev 1.0
// ============================================================================
`default_nettype none

package fir_mc_pkg;

   typedef logic [1:0] fir_state_t;

   localparam fir_state_t ST_IDLE = 2'd0;
   localparam fir_state_t ST_MAC  = 2'd1;
   localparam fir_state_t ST_OUT  = 2'd2;

   // Index width that never collapses to zero bits, even for a single entry.
   function automatic int fir_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Full product width plus enough guard bits to sum every tap without overflow.
   function automatic int fir_acc_width(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fir_round_sat.sv
// ============================================================================
// fir_round_sat : round-half-up, arithmetic shift and saturate to DATA_WIDTH
// Rev 1.0
// ============================================================================
`default_nettype none

module fir_round_sat #(
   parameter int ACC_WIDTH  = 36,
   parameter int DATA_WIDTH = 16,
   parameter int OUT_SHIFT  = 15
) (
   input  logic signed [ACC_WIDTH-1:0]  i_acc,
   output logic signed [DATA_WIDTH-1:0] o_data,
   output logic                         o_sat
);

   // One extra bit so adding the rounding constant cannot wrap.
   localparam logic signed [ACC_WIDTH:0] c_half =
      {{ACC_WIDTH{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
   localparam logic signed [ACC_WIDTH:0] c_max =
      {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] c_min =
      {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH:0] w_sum;
   logic signed [ACC_WIDTH:0] w_shr;

   assign w_sum = {i_acc[ACC_WIDTH-1], i_acc} + c_half;
   assign w_shr = w_sum >>> OUT_SHIFT;

   always_comb begin
      o_sat  = 1'b0;
      o_data = w_shr[DATA_WIDTH-1:0];
      if (w_shr > c_max) begin
         o_sat  = 1'b1;
         o_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (w_shr < c_min) begin
         o_sat  = 1'b1;
         o_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
   end

endmodule

`default_nettype wire

// File: rtl/fir_filter_mc.sv
// ============================================================================
// fir_filter_mc : time-multiplexed multi-channel FIR, one shared MAC
// Rev 1.0
// ============================================================================
`default_nettype none

module fir_filter_mc
   import fir_mc_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int COEFF_WIDTH = 16,
   parameter int NUM_TAPS    = 32,
   parameter int NUM_CH      = 4,
   parameter int OUT_SHIFT   = 15,
   localparam int CH_W       = fir_width(NUM_CH),
   localparam int TAP_W      = fir_width(NUM_TAPS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CH_W-1:0]               in_ch,
   input  logic signed [DATA_WIDTH-1:0]  in_data,
   input  logic                          coeff_we,
   input  logic [TAP_W-1:0]              coeff_addr,
   input  logic signed [COEFF_WIDTH-1:0] coeff_wdata,
   output logic                          out_valid,
   output logic [CH_W-1:0]               out_ch,
   output logic signed [DATA_WIDTH-1:0]  out_data,
   output logic                          out_sat,
   output logic                          coeff_err,
   output logic                          ch_err
);

   localparam int ACC_WIDTH = fir_acc_width(DATA_WIDTH, COEFF_WIDTH, NUM_TAPS);
   localparam int PROD_W    = DATA_WIDTH + COEFF_WIDTH;

   localparam logic [CH_W:0]    c_num_ch   = (CH_W+1)'(NUM_CH);
   localparam logic [TAP_W:0]   c_num_taps = (TAP_W+1)'(NUM_TAPS);
   localparam logic [TAP_W-1:0] c_last_tap = TAP_W'(NUM_TAPS - 1);

   fir_state_t                    r_state;
   logic                          r_in_ready;
   logic                          r_out_valid;
   logic [CH_W-1:0]               r_out_ch;
   logic signed [DATA_WIDTH-1:0]  r_out_data;
   logic                          r_out_sat;
   logic                          r_coeff_err;
   logic                          r_ch_err;
   logic [CH_W-1:0]               r_ch;
   logic [TAP_W-1:0]              r_k;
   logic [TAP_W-1:0]              r_idx;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic signed [COEFF_WIDTH-1:0] r_coeff [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0]  r_hist  [NUM_CH][NUM_TAPS];
   logic [TAP_W-1:0]              r_wptr  [NUM_CH];

   logic                          w_accept;
   logic                          w_ch_ok;
   logic                          w_addr_ok;
   logic [TAP_W-1:0]              w_wptr;
   logic [TAP_W-1:0]              w_wptr_nxt;
   logic [TAP_W-1:0]              w_idx_nxt;
   logic signed [PROD_W-1:0]      w_prod;
   logic signed [ACC_WIDTH-1:0]   w_prod_ext;
   logic signed [DATA_WIDTH-1:0]  w_rs_data;
   logic                          w_rs_sat;

   assign w_accept   = in_valid & r_in_ready;
   assign w_ch_ok    = ({1'b0, in_ch} < c_num_ch);
   assign w_addr_ok  = ({1'b0, coeff_addr} < c_num_taps);
   assign w_wptr     = r_wptr[in_ch];
   assign w_wptr_nxt = (w_wptr == c_last_tap) ? '0 : w_wptr + 1'b1;

   // Walk backwards through the circular history: x[n], x[n-1], ...
   assign w_idx_nxt  = (r_idx == '0) ? c_last_tap : r_idx - 1'b1;

   assign w_prod     = r_coeff[r_k] * r_hist[r_ch][r_idx];
   assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};

   fir_round_sat #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_SHIFT  (OUT_SHIFT)
   ) u_round_sat (
      .i_acc  (r_acc),
      .o_data (w_rs_data),
      .o_sat  (w_rs_sat)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_coeff_err <= 1'b0;
         r_ch_err    <= 1'b0;
         r_ch        <= '0;
         r_k         <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         for (int t = 0; t < NUM_TAPS; t++) begin
            r_coeff[t] <= '0;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            r_wptr[c] <= '0;
            for (int t = 0; t < NUM_TAPS; t++) begin
               r_hist[c][t] <= '0;
            end
         end
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_in_ready <= 1'b1;
               // A write landing with an accepted sample is visible to its MAC pass.
               if (coeff_we) begin
                  if (w_addr_ok) begin
                     r_coeff[coeff_addr] <= coeff_wdata;
                  end else begin
                     r_coeff_err <= 1'b1;
                  end
               end
               if (w_accept) begin
                  if (w_ch_ok) begin
                     r_hist[in_ch][w_wptr] <= in_data;
                     r_wptr[in_ch]         <= w_wptr_nxt;
                     r_ch                  <= in_ch;
                     r_idx                 <= w_wptr;
                     r_k                   <= '0;
                     r_acc                 <= '0;
                     r_in_ready            <= 1'b0;
                     r_state               <= ST_MAC;
                  end else begin
                     r_ch_err <= 1'b1;
                  end
               end
            end
            ST_MAC: begin
               if (coeff_we) begin
                  r_coeff_err <= 1'b1;
               end
               r_acc <= r_acc + w_prod_ext;
               r_idx <= w_idx_nxt;
               r_k   <= r_k + 1'b1;
               if (r_k == c_last_tap) begin
                  r_state <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (coeff_we) begin
                  r_coeff_err <= 1'b1;
               end
               r_out_valid <= 1'b1;
               r_out_ch    <= r_ch;
               r_out_data  <= w_rs_data;
               r_out_sat   <= w_rs_sat;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_in_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_ch    = r_out_ch;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;
   assign coeff_err = r_coeff_err;
   assign ch_err    = r_ch_err;

endmodule

`default_nettype wire

// File: doc/fir_filter_mc.md
Name: fir_filter_mc

Overview:
Parametrised successor to the single-channel digital filter. A time-multiplexed FIR with one multiply-accumulate unit serves NUM_CH independent channels. Coefficients are runtime-programmable and shared by all channels. Each channel keeps its own delay line. Sits between the sample ingress interface and downstream DSP. Output is Q-format rounded and saturated, with a valid/ready input handshake.

Parameters:
DATA_WIDTH, 16, signed sample width (in and out)
COEFF_WIDTH, 16, signed coefficient width
NUM_TAPS, 32, taps per channel (>=2)
NUM_CH, 4, channel count (>=1, need not be a power of 2)
OUT_SHIFT, 15, right-shift applied to the accumulator (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
in_valid  in  1  sample present
in_ready  out  1  block can accept a sample
in_ch  in  CH_W=max(1,clog2(NUM_CH))  channel of sample
in_data  in  DATA_WIDTH  signed sample
coeff_we  in  1  coefficient write strobe
coeff_addr  in  TAP_W=clog2(NUM_TAPS)  tap index
coeff_wdata  in  COEFF_WIDTH  signed coefficient
out_valid  out  1  one-cycle result pulse
out_ch  out  CH_W  channel of result
out_data  out  DATA_WIDTH  signed result
out_sat  out  1  result was saturated (qualified by out_valid)
coeff_err  out  1  sticky: a coefficient write was dropped
ch_err  out  1  sticky: a sample with in_ch >= NUM_CH was discarded

Behaviour:
- Reset (rst=0 at an edge): all outputs 0 except in_ready=0. Coefficients, all history and per-channel write pointers are cleared. FSM goes to IDLE. In the cycle after reset is released, in_ready=1.
- Reset mid-operation aborts the computation. No out_valid is produced for it.
- FSM states are IDLE, MAC and OUT.
- IDLE: in_ready=1. On in_valid&&in_ready with a valid in_ch, the block:
  - writes in_data into that channel's circular history at its pointer, then advances the pointer with wrap (NUM_TAPS-1 -> 0);
  - latches the channel, clears the accumulator and goes to MAC.
- If in_ch >= NUM_CH, the sample is consumed, ch_err is set and the FSM stays in IDLE.
- MAC: in_ready=0. Lasts exactly NUM_TAPS cycles, k = 0..NUM_TAPS-1, with acc += coeff[k] * x[n-k].
  - x[n] is the sample just written.
  - History index wraps modulo NUM_TAPS.
- ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + clog2(NUM_TAPS). The accumulator is signed and never overflows.
- OUT: one cycle.
  - Compute r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half toward +inf, arithmetic shift.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. out_sat=1 if clipped.
  - Register the result: out_valid pulses for 1 cycle with out_ch and out_data. Return to IDLE.
  - out_data and out_ch hold their value until the next result.
- Latency: handshake at edge T gives out_valid high in cycle T+NUM_TAPS+2. Throughput is one sample per NUM_TAPS+2 cycles.
- Coefficient writes:
  - Applied only while the FSM is in IDLE.
  - coeff_we in MAC or OUT is dropped and sets coeff_err.
  - A coeff_we in the same IDLE cycle as an accepted sample is applied, and that computation uses the new value.
- Sticky flags clear only on reset.
- in_valid held while in_ready=0 is legal. The sample is taken on the first IDLE cycle.

Decomposition:
- Package fir_mc_pkg holds:
  - state enum (IDLE, MAC, OUT);
  - a clog2-based width function;
  - the ACC_WIDTH derivation.
- One sub-module, fir_round_sat: purely combinational round/shift/saturate. Parameters ACC_WIDTH, DATA_WIDTH and OUT_SHIFT; outputs data and sat.
- Coefficient and history storage stay in the top level as register arrays.

Test Plan:
1. Reset, then ch0 sample 100 with all coefficients 0 -> out_valid exactly 34 cycles after the handshake, out_ch=0, out_data=0, out_sat=0.
2. coeff[k]=(k+1)*64. On ch0, send 16384, then 33 zeros -> out_data = 32, 64, ..., 1024 (32 values), then 0, 0.
3. Interleave ch0 (the impulse from test 2) with ch1 sample 0 each time -> ch1 outputs are all 0, and the ch0 sequence is identical to test 2.
4. All coefficients 0x7FFF, ch2 fed 32767 twice -> first out_data=32766, sat=0; second 32767, sat=1. Feeding -32768 repeatedly then reaches -32768 with sat=1.
5. coeff[0]=1, others 0, ch3 samples 16384, 16383, -16384 -> outputs 1, 0, 0.
6. Hold in_valid during MAC -> in_ready=0 and no second accept. coeff_we during MAC -> coeff_err=1 and the coefficient is unchanged. in_ch=5 in IDLE -> ch_err=1 and no output. Reset asserted mid-MAC -> out_valid stays 0, and in_ready=1 one cycle after release.
